// File: rtl/uart_term_pkg.sv
// Shared types and helpers for the uart_term receive terminal.
package uart_term_pkg;

  // Parity selection encoding for the PARITY parameter.
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Receive FSM states. IDLE is the reset state.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  // 2-of-3 majority, used to vote each bit from three mid-bit samples.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // FIFO entry width: {perr, ferr, data}.
  function automatic int entry_width(input int data_bits);
    return data_bits + 2;
  endfunction

endpackage

// File: rtl/uart_term_fifo.sv
// Synchronous show-ahead FIFO. Pointers carry one extra wrap bit so full and
// empty are told apart without a separate counter. When full, a push is
// accepted only if a pop happens in the same cycle.
module uart_term_fifo
  import uart_term_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Head is shown directly; forced to zero when empty so it has a defined value.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // Pointer registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write.
  // NOTE: the storage array is deliberately not reset; emptiness is tracked by
  // the pointers, and resetting the array would only cost flops and routing.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_term_rx.sv
// UART receive terminal: 2-flop synchronizer, clock-counted bit timing with a
// 3-sample majority vote per bit, configurable framing, and a receive FIFO
// that stores per-character framing and parity error flags.
module uart_term_rx
  import uart_term_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  input  logic                          rx,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_ferr,
  output logic                          rd_perr,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overrun,
  input  logic                          clr_ovr
);

  localparam int EW = entry_width(DATA_BITS);
  localparam int PW = $clog2(CLKS_PER_BIT);
  localparam int H  = CLKS_PER_BIT / 2;

  // Phase actions are keyed on the value the counter steps into on that edge:
  // the counter reads (p-1) in the cycle whose closing edge is phase p.
  localparam logic [PW-1:0] PH_SAMP_A = PW'(H - 2);      // edge of phase H-1
  localparam logic [PW-1:0] PH_SAMP_B = PW'(H - 1);      // edge of phase H
  localparam logic [PW-1:0] PH_VOTE   = PW'(H);          // edge of phase H+1
  localparam logic [PW-1:0] PH_LAST   = PW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] PH_ONE    = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic          ODD_PAR   = (PARITY == PAR_ODD);

  // Synchronizer and edge history.
  logic sync1_q, rx_s_q, rx_prev_q;

  // Bit timing and vote samples.
  logic [PW-1:0] phase_q, phase_d;
  logic          samp_a_q, samp_b_q;
  logic          vote;
  logic          vote_now;

  // Frame assembly.
  state_e                 state_q, state_d;
  logic [3:0]             bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   ferr_q, ferr_d;
  logic                   perr_q, perr_d;

  // Registered push towards the FIFO.
  logic                   push_q, push_d;
  logic [EW-1:0]          entry_q, entry_d;

  // FIFO and overrun.
  logic [EW-1:0]          fifo_rdata;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   ovr_set;
  logic                   overrun_q;

  assign vote     = maj3(samp_a_q, samp_b_q, rx_s_q);
  assign vote_now = (phase_q == PH_VOTE);

  // Two-flop synchronizer on the asynchronous line plus one history flop.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= rx;
      rx_s_q    <= sync1_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // Capture the first two of the three mid-bit samples.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      samp_a_q <= 1'b1;
      samp_b_q <= 1'b1;
    end else begin
      if (phase_q == PH_SAMP_A) samp_a_q <= rx_s_q;
      if (phase_q == PH_SAMP_B) samp_b_q <= rx_s_q;
    end
  end

  // Next-state logic: phase counter, bit index, shift register, error flags.
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    ferr_d    = ferr_q;
    perr_d    = perr_q;
    push_d    = 1'b0;
    entry_d   = entry_q;
    phase_d   = (phase_q == PH_LAST) ? '0 : phase_q + PH_ONE;

    unique case (state_q)
      ST_IDLE: begin
        phase_d = '0;
        if (rx_prev_q && !rx_s_q) begin
          state_d   = ST_START;
          bit_idx_d = '0;
          ferr_d    = 1'b0;
          perr_d    = 1'b0;
        end
      end

      ST_START: begin
        if (vote_now) begin
          // A start bit that votes high was a glitch on an idle line.
          state_d = vote ? ST_IDLE : ST_DATA;
        end
      end

      ST_DATA: begin
        if (vote_now) begin
          shift_d = {vote, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == LAST_DATA) begin
            bit_idx_d = '0;
            state_d   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end

      ST_PARITY: begin
        if (vote_now) begin
          perr_d  = ((^shift_q) ^ vote) != ODD_PAR;
          state_d = ST_STOP;
        end
      end

      ST_STOP: begin
        if (vote_now) begin
          if (!vote) ferr_d = 1'b1;
          if (bit_idx_q == LAST_STOP) begin
            // Resynchronise mid-stop: hand the frame over and look for the
            // next falling edge straight away.
            push_d  = 1'b1;
            entry_d = {perr_d, ferr_d, shift_q};
            state_d = ST_IDLE;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and datapath registers.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      push_q    <= 1'b0;
      entry_q   <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
      push_q    <= push_d;
      entry_q   <= entry_d;
    end
  end

  // A push into a full FIFO is lost unless a pop frees a slot that same cycle.
  assign ovr_set = push_q && fifo_full && !rd_en;

  // Sticky overrun flag; a new drop wins over a simultaneous clear.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      overrun_q <= 1'b0;
    end else if (ovr_set) begin
      overrun_q <= 1'b1;
    end else if (clr_ovr) begin
      overrun_q <= 1'b0;
    end
  end

  uart_term_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (HCLK),
    .rst_i   (HRESET),
    .push_i  (push_q),
    .wdata_i (entry_q),
    .pop_i   (rd_en),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  assign rd_data  = fifo_rdata[DATA_BITS-1:0];
  assign rd_ferr  = fifo_rdata[DATA_BITS];
  assign rd_perr  = fifo_rdata[DATA_BITS+1];
  assign rd_valid = !fifo_empty;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_uart_term_rx.sv
// Self-checking bench for uart_term_rx. Three instances share clock and reset:
// u_d0 is 8N1 with an 8-deep FIFO, u_d1 uses even parity, u_d2 has a 4-deep
// FIFO for the overrun cases. Inputs change on the falling clock edge and
// outputs are read there too, half a cycle away from the active edge.
module tb_uart_term_rx;

  localparam int CPB = 16;

  logic HCLK = 1'b0;
  logic HRESET;
  logic rx_l    [3];
  logic rd_en_l [3];
  logic clr_l   [3];

  logic [7:0] rd_data0, rd_data1, rd_data2;
  logic       rd_ferr0, rd_ferr1, rd_ferr2;
  logic       rd_perr0, rd_perr1, rd_perr2;
  logic       rd_valid0, rd_valid1, rd_valid2;
  logic [3:0] level0, level1;
  logic [2:0] level2;
  logic       overrun0, overrun1, overrun2;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 HCLK = ~HCLK;

  uart_term_rx u_d0 (
    .HCLK(HCLK), .HRESET(HRESET), .rx(rx_l[0]), .rd_en(rd_en_l[0]),
    .rd_data(rd_data0), .rd_ferr(rd_ferr0), .rd_perr(rd_perr0),
    .rd_valid(rd_valid0), .level(level0), .overrun(overrun0), .clr_ovr(clr_l[0])
  );

  uart_term_rx #(.PARITY(2)) u_d1 (
    .HCLK(HCLK), .HRESET(HRESET), .rx(rx_l[1]), .rd_en(rd_en_l[1]),
    .rd_data(rd_data1), .rd_ferr(rd_ferr1), .rd_perr(rd_perr1),
    .rd_valid(rd_valid1), .level(level1), .overrun(overrun1), .clr_ovr(clr_l[1])
  );

  uart_term_rx #(.FIFO_DEPTH(4)) u_d2 (
    .HCLK(HCLK), .HRESET(HRESET), .rx(rx_l[2]), .rd_en(rd_en_l[2]),
    .rd_data(rd_data2), .rd_ferr(rd_ferr2), .rd_perr(rd_perr2),
    .rd_valid(rd_valid2), .level(level2), .overrun(overrun2), .clr_ovr(clr_l[2])
  );

  typedef struct {
    logic [7:0] data;
    int         glitch_k;   // line bit index to glitch at mid-bit, -1 for none
    logic       stop_v;     // value driven on the stop bit
    logic [7:0] exp_data;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Line image of one frame: bit 0 start, LSB-first data, optional parity, stop.
  function automatic logic [15:0] mk_frame(input logic [7:0] d, input bit has_par,
                                           input logic pbit, input logic stop_v);
    logic [15:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
    if (has_par) begin
      f[9]  = pbit;
      f[10] = stop_v;
    end else begin
      f[9]  = stop_v;
    end
    return f;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge HCLK);
      for (int s = 0; s < 3; s++) rx_l[s] = 1'b1;
    end
  endtask

  // Drives a frame on instance sel. With the start bit set at falling edge n0,
  // the first rising edge after it samples low and T0 is the third rising edge
  // counting that one. The last stop vote (push) falls on the rising edge
  // before iteration nbits*16-4 and the FIFO write on the edge after it, so
  // optional rd_en/clr_ovr pulses driven in that iteration hit the write edge.
  task automatic send_frame(input int sel, input logic [15:0] frame, input int nbits,
                            input int glitch_k, input bit pop_at_push,
                            input bit clr_at_push, input bit chk_timing,
                            input int stop_after);
    int   ncyc;
    int   push_i;
    logic v;
    ncyc   = (stop_after > 0) ? stop_after : nbits * CPB;
    push_i = nbits * CPB - 4;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge HCLK);
      if (chk_timing && i == push_i) check("rd_valid_at_T0+153", {31'd0, rd_valid0}, 32'd0);
      if (chk_timing && i == push_i + 1) begin
        check("rd_valid_at_T0+154", {31'd0, rd_valid0}, 32'd1);
        check("level_at_T0+154", {28'd0, level0}, 32'd1);
      end
      rd_en_l[sel] = pop_at_push && (i == push_i);
      clr_l[sel]   = clr_at_push && (i == push_i);
      v = frame[i / CPB];
      if ((i / CPB) == glitch_k && (i % CPB) == (CPB / 2)) v = ~v;
      rx_l[sel] = v;
    end
  endtask

  task automatic send8n1(input int sel, input logic [7:0] d);
    send_frame(sel, mk_frame(d, 1'b0, 1'b0, 1'b1), 10, -1, 1'b0, 1'b0, 1'b0, 0);
    idle(4);
  endtask

  task automatic pop(input int sel);
    @(negedge HCLK);
    rd_en_l[sel] = 1'b1;
    @(negedge HCLK);
    rd_en_l[sel] = 1'b0;
  endtask

  task automatic pulse_clr(input int sel);
    @(negedge HCLK);
    clr_l[sel] = 1'b1;
    @(negedge HCLK);
    clr_l[sel] = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h41, -1, 1'b1, 8'h41, 1'b0};
    vecs[1] = '{8'h55,  4, 1'b1, 8'h55, 1'b0};  // one-cycle flip at mid data bit 3
    vecs[2] = '{8'h00, -1, 1'b1, 8'h00, 1'b0};
    vecs[3] = '{8'hFF,  0, 1'b1, 8'hFF, 1'b0};  // flip at mid start bit
    vecs[4] = '{8'hA5, -1, 1'b0, 8'hA5, 1'b1};  // stop bit low
    vecs[5] = '{8'h80,  8, 1'b1, 8'h80, 1'b0};  // flip at mid data bit 7

    for (int s = 0; s < 3; s++) begin
      rx_l[s] = 1'b1; rd_en_l[s] = 1'b0; clr_l[s] = 1'b0;
    end
    HRESET = 1'b1;
    repeat (4) @(negedge HCLK);

    // Reset state.
    check("reset_rd_valid", {31'd0, rd_valid0}, 32'd0);
    check("reset_level",    {28'd0, level0}, 32'd0);
    check("reset_rd_data",  {24'd0, rd_data0}, 32'd0);
    check("reset_flags",    {29'd0, rd_ferr0, rd_perr0, overrun0}, 32'd0);
    HRESET = 1'b0;
    idle(10);

    // Short low pulse on an idle line is a false start.
    for (int i = 0; i < 4; i++) begin
      @(negedge HCLK);
      rx_l[0] = 1'b0;
    end
    idle(60);
    check("pulse_rd_valid", {31'd0, rd_valid0}, 32'd0);
    check("pulse_level",    {28'd0, level0}, 32'd0);

    // Table-driven frames on the 8N1 instance.
    for (int v = 0; v < 6; v++) begin
      send_frame(0, mk_frame(vecs[v].data, 1'b0, 1'b0, vecs[v].stop_v), 10,
                 vecs[v].glitch_k, 1'b0, 1'b0, (v == 0), 0);
      idle(6);
      check($sformatf("vec%0d_rd_valid", v), {31'd0, rd_valid0}, 32'd1);
      check($sformatf("vec%0d_level", v),    {28'd0, level0}, 32'd1);
      check($sformatf("vec%0d_rd_data", v),  {24'd0, rd_data0}, {24'd0, vecs[v].exp_data});
      check($sformatf("vec%0d_ferr", v),     {31'd0, rd_ferr0}, {31'd0, vecs[v].exp_ferr});
      check($sformatf("vec%0d_perr", v),     {31'd0, rd_perr0}, 32'd0);
      pop(0);
      check($sformatf("vec%0d_popped", v),   {28'd0, level0}, 32'd0);
    end

    // Break: line held low for 20 bit times gives one entry with ferr set.
    @(negedge HCLK);
    rx_l[0] = 1'b0;
    repeat (20 * CPB - 1) @(negedge HCLK);
    idle(40);
    check("break_level", {28'd0, level0}, 32'd1);
    check("break_data",  {24'd0, rd_data0}, 32'd0);
    check("break_ferr",  {31'd0, rd_ferr0}, 32'd1);
    check("break_perr",  {31'd0, rd_perr0}, 32'd0);
    pop(0);
    send8n1(0, 8'h5A);
    check("after_break_data",  {24'd0, rd_data0}, 32'h5A);
    check("after_break_ferr",  {31'd0, rd_ferr0}, 32'd0);
    check("after_break_level", {28'd0, level0}, 32'd1);
    pop(0);

    // Even parity: 0x03 has an even number of ones, so parity bit 1 is wrong.
    send_frame(1, mk_frame(8'h03, 1'b1, 1'b1, 1'b1), 11, -1, 1'b0, 1'b0, 1'b0, 0);
    idle(6);
    check("par1_data", {24'd0, rd_data1}, 32'h03);
    check("par1_perr", {31'd0, rd_perr1}, 32'd1);
    check("par1_ferr", {31'd0, rd_ferr1}, 32'd0);
    pop(1);
    send_frame(1, mk_frame(8'h03, 1'b1, 1'b0, 1'b1), 11, -1, 1'b0, 1'b0, 1'b0, 0);
    idle(6);
    check("par0_data",  {24'd0, rd_data1}, 32'h03);
    check("par0_perr",  {31'd0, rd_perr1}, 32'd0);
    check("par0_level", {28'd0, level1}, 32'd1);
    pop(1);

    // Overrun on the 4-deep instance: fifth frame is dropped.
    for (int j = 0; j < 5; j++) send8n1(2, 8'h10 + 8'(j));
    check("ovr_level",   {29'd0, level2}, 32'd4);
    check("ovr_flag",    {31'd0, overrun2}, 32'd1);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("ovr_pop%0d", j), {24'd0, rd_data2}, 32'h10 + j);
      pop(2);
    end
    check("ovr_drained", {31'd0, rd_valid2}, 32'd0);
    pulse_clr(2);
    check("ovr_cleared", {31'd0, overrun2}, 32'd0);

    // Refill, then pop in the write cycle of a fifth frame: no overrun.
    for (int j = 0; j < 4; j++) send8n1(2, 8'h20 + 8'(j));
    check("refill_level", {29'd0, level2}, 32'd4);
    send_frame(2, mk_frame(8'h24, 1'b0, 1'b0, 1'b1), 10, -1, 1'b1, 1'b0, 1'b0, 0);
    idle(4);
    pulse_clr(2);
    check("pushpop_overrun", {31'd0, overrun2}, 32'd0);
    check("pushpop_level",   {29'd0, level2}, 32'd4);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("pushpop_pop%0d", j), {24'd0, rd_data2}, 32'h21 + j);
      pop(2);
    end

    // Drop coinciding with clr_ovr: setting wins.
    for (int j = 0; j < 4; j++) send8n1(2, 8'h30 + 8'(j));
    send_frame(2, mk_frame(8'h34, 1'b0, 1'b0, 1'b1), 10, -1, 1'b0, 1'b1, 1'b0, 0);
    idle(4);
    check("set_over_clr", {31'd0, overrun2}, 32'd1);
    check("set_over_clr_level", {29'd0, level2}, 32'd4);

    // Reset in the middle of data bit 4, with a stored entry on u_d0 and a
    // full, overrun u_d2.
    send8n1(0, 8'h11);
    check("pre_reset_level", {28'd0, level0}, 32'd1);
    send_frame(0, mk_frame(8'h3C, 1'b0, 1'b0, 1'b1), 10, -1, 1'b0, 1'b0, 1'b0, 5 * CPB + 8);
    @(negedge HCLK);
    HRESET  = 1'b1;
    rx_l[0] = 1'b1;
    #1;
    check("rst_rd_valid", {31'd0, rd_valid0}, 32'd0);
    check("rst_level",    {28'd0, level0}, 32'd0);
    check("rst_overrun",  {31'd0, overrun2}, 32'd0);
    check("rst_level2",   {29'd0, level2}, 32'd0);
    repeat (3) @(negedge HCLK);
    HRESET = 1'b0;
    idle(20);
    send8n1(0, 8'hA5);
    check("post_reset_data",  {24'd0, rd_data0}, 32'hA5);
    check("post_reset_level", {28'd0, level0}, 32'd1);
    check("post_reset_ferr",  {31'd0, rd_ferr0}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
